bus_arbiter_5w: RTL and testbench

Round-robin arbiter that shares one 8-bit, five-source bus mux among five requesters (ALU, IP, AP, I/O, front panel). It owns the mux select. It issues a one-hot grant with a hold-until-release handshake and inserts one idle cycle between owners. Sits between the requesting units and the 5-way byte mux of the data path.

---
 rtl/bus_arbiter_5w.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter_5w.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_5w.sv
// ============================================================================
// Module   : bus_arbiter_5w
// Brief    : Five-source round-robin bus arbiter. It drives a one-hot grant
//            and the byte-mux select, holds each grant until the owner
//            releases it, and puts one idle cycle between owners.
// Options  : BUS_ARBITER_WATCHDOG_EN - when defined, a grant is revoked after
//            TIMEOUT cycles and the revoked source stays blocked until it
//            drops its request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_5w #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] req_i,
  output logic [4:0] gnt_o,
  output logic [2:0] sel_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam logic [2:0] SEL_NONE = 3'b111;
  localparam logic [2:0] LAST_RST = 3'd4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e     state_q;
  logic [4:0] gnt_q;
  logic [2:0] sel_q;      // doubles as the owner index while granted
  logic [2:0] last_q;
  logic       busy_q;
  logic [4:0] blk_q;

  logic [4:0] masked_req;
  logic       pick_vld;
  logic [2:0] pick_idx;
  logic       owner_req;

`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam int         CW  = $clog2(TIMEOUT + 1);
  // The revoke edge is the one where the count would reach TIMEOUT.
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;
  logic          wd_hit;

  assign wd_hit    = (cnt_q == LIM);
  assign timeout_o = timeout_q;
`else
  assign blk_q     = 5'b0;
  assign timeout_o = 1'b0;
`endif

  // gnt_q is one-hot on the owner, so this reads the owner's request line.
  assign owner_req = |(req_i & gnt_q);
  assign masked_req = req_i & ~blk_q;

  // Round-robin search starting just after the last owner; scanning from the
  // farthest candidate down leaves the nearest eligible one selected.
  always_comb begin
    int cand;
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    for (int k = 5; k >= 1; k--) begin
      cand = int'(last_q) + k;
      if (cand >= 5) cand = cand - 5;
      if (masked_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = 3'(cand);
      end
    end
  end

  // Arbitration FSM with registered grant, select, busy and watchdog state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      gnt_q     <= 5'b0;
      sel_q     <= SEL_NONE;
      last_q    <= LAST_RST;
      busy_q    <= 1'b0;
`ifdef BUS_ARBITER_WATCHDOG_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      blk_q     <= 5'b0;
`endif
    end else begin
`ifdef BUS_ARBITER_WATCHDOG_EN
      timeout_q <= 1'b0;
      // A blocked source is released once it has dropped its request.
      blk_q     <= blk_q & req_i;
`endif
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            state_q <= S_GRANT;
            gnt_q   <= 5'b00001 << pick_idx;
            sel_q   <= pick_idx;
            last_q  <= pick_idx;
            busy_q  <= 1'b1;
`ifdef BUS_ARBITER_WATCHDOG_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (!owner_req) begin
            state_q <= S_IDLE;
            gnt_q   <= 5'b0;
            sel_q   <= SEL_NONE;
            busy_q  <= 1'b0;
`ifdef BUS_ARBITER_WATCHDOG_EN
          end else if (wd_hit) begin
            state_q   <= S_IDLE;
            gnt_q     <= 5'b0;
            sel_q     <= SEL_NONE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            blk_q     <= (blk_q & req_i) | gnt_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;
  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_5w.sv
// ============================================================================
// Module   : tb_bus_arbiter_5w
// Brief    : Self-checking bench for bus_arbiter_5w: vector table, directed
//            corner sequences and random requests against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_5w;

`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
  localparam int T  = 4;
`else
  localparam bit WD = 1'b0;
  localparam int T  = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       tout;

  bus_arbiter_5w #(.TIMEOUT(T)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .busy_o    (busy),
    .timeout_o (tout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: owner index (-1 = none), last winner, block mask,
  // cycles the current owner has held the bus, and the revoke pulse.
  int       m_owner;
  int       m_last;
  bit [4:0] m_blk;
  int       m_held;
  bit       m_to;

  task automatic model_reset();
    m_owner = -1; m_last = 4; m_blk = 5'b0; m_held = 0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] r);
    bit [4:0] nb;
    bit       found;
    int       idx;
    nb   = m_blk & r;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        idx = (m_last + k) % 5;
        if (!found && r[idx] && !m_blk[idx]) begin
          found = 1'b1; m_owner = idx; m_last = idx; m_held = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (WD && m_held == T) begin
      nb[m_owner] = 1'b1; m_to = 1'b1; m_owner = -1;
    end else begin
      m_held++;
    end
    m_blk = nb;
  endtask

  task automatic cmp_model(input string tag);
    int eg, es;
    eg = (m_owner < 0) ? 0 : (1 << m_owner);
    es = (m_owner < 0) ? 7 : m_owner;
    check({tag, ".gnt"}, gnt, eg);
    check({tag, ".sel"}, sel, es);
    check({tag, ".busy"}, busy, (m_owner >= 0) ? 1 : 0);
    check({tag, ".timeout"}, tout, m_to);
  endtask

  // Apply one request vector for one clock edge; sample 1 ns after the edge.
  task automatic drive(input logic [4:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] r);
    @(negedge clk);
    rst_n = 1'b0;
    req   = r;
    model_reset();
    #1;
    check("rst.gnt", gnt, 0);
    check("rst.sel", sel, 7);
    check("rst.busy", busy, 0);
    check("rst.timeout", tout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] r;
    logic [4:0] g;
    logic [2:0] s;
  } vec_t;

  vec_t tv[15];

  initial begin
    int       order[$];
    int       idle_run;
    int       cnt_g1, cnt_g4, cnt_to;
    logic [4:0] r, prev;
    bit       seen_grant;
    int       exp_order[6];

    rst_n = 1'b1;
    req   = 5'b0;
    model_reset();

    // ---------------- vector table ----------------
    tv[0]  = '{5'b11111, 5'b00001, 3'd0};
    tv[1]  = '{5'b11111, 5'b00001, 3'd0};
    tv[2]  = '{5'b11110, 5'b00000, 3'd7};
    tv[3]  = '{5'b11111, 5'b00010, 3'd1};
    tv[4]  = '{5'b00001, 5'b00000, 3'd7};
    tv[5]  = '{5'b00101, 5'b00100, 3'd2};
    tv[6]  = '{5'b00101, 5'b00100, 3'd2};
    tv[7]  = '{5'b00001, 5'b00000, 3'd7};
    tv[8]  = '{5'b00000, 5'b00000, 3'd7};
    tv[9]  = '{5'b10000, 5'b10000, 3'd4};
    tv[10] = '{5'b01000, 5'b00000, 3'd7};
    tv[11] = '{5'b00000, 5'b00000, 3'd7};
    tv[12] = '{5'b01001, 5'b00001, 3'd0};
    tv[13] = '{5'b01000, 5'b00000, 3'd7};
    tv[14] = '{5'b01000, 5'b01000, 3'd3};

    do_reset(5'b11111);
    for (int i = 0; i < 15; i++) begin
      drive(tv[i].r);
      check($sformatf("tv%0d.gnt", i), gnt, tv[i].g);
      check($sformatf("tv%0d.sel", i), sel, tv[i].s);
      check($sformatf("tv%0d.busy", i), busy, (tv[i].g != 0) ? 1 : 0);
    end

    // ---------------- round robin with 3-cycle holds ----------------
    do_reset(5'b11111);
    exp_order = '{0, 1, 2, 3, 4, 0};
    idle_run = 0;
    seen_grant = 1'b0;
    prev = 5'b0;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      r = 5'b11111;
      if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
      drive(r);
      cmp_model("rr");
      if (gnt == 5'b0) idle_run++;
      else if (prev == 5'b0) begin
        if (seen_grant) check("rr.idle_cycles", idle_run, 1);
        order.push_back(int'(sel));
        seen_grant = 1'b1;
        idle_run = 0;
      end
      prev = gnt;
    end
    check("rr.grants", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check($sformatf("rr.order%0d", i), order[i], exp_order[i]);

    // ---------------- no preemption ----------------
    do_reset(5'b00000);
    drive(5'b00100);
    check("np.grant2", gnt, 5'b00100);
    for (int i = 0; i < 3; i++) begin
      drive(5'b00101);
      check("np.hold", gnt, 5'b00100);
      cmp_model("np");
    end
    drive(5'b00001);
    check("np.idle.gnt", gnt, 0);
    check("np.idle.sel", sel, 7);
    drive(5'b00001);
    check("np.grant0", gnt, 5'b00001);
    check("np.sel0", sel, 0);

    // ---------------- asynchronous reset mid-grant ----------------
    do_reset(5'b00000);
    drive(5'b01000);
    drive(5'b01000);
    check("ar.grant3", gnt, 5'b01000);
    #2;
    rst_n = 1'b0;
    req   = 5'b01010;
    model_reset();
    #1;
    check("ar.async.gnt", gnt, 0);
    check("ar.async.sel", sel, 7);
    check("ar.async.busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'b01010);
    check("ar.regrant1", gnt, 5'b00010);
    cmp_model("ar");

    // ---------------- watchdog / long hold ----------------
    do_reset(5'b00000);
    cnt_g1 = 0; cnt_g4 = 0; cnt_to = 0;
    if (WD) begin
      for (int i = 0; i < 8; i++) begin
        drive(5'b10010);
        cmp_model("wd");
        if (gnt == 5'b00010) cnt_g1++;
        if (gnt == 5'b10000) cnt_g4++;
        if (tout) cnt_to++;
      end
      check("wd.gnt1_cycles", cnt_g1, 4);
      check("wd.timeout_pulses", cnt_to, 1);
      check("wd.gnt4_cycles", cnt_g4, 3);
      for (int i = 0; i < 6; i++) begin
        drive(5'b00010);
        cmp_model("wd.blocked");
      end
      check("wd.still_blocked", gnt, 0);
      drive(5'b00000);
      cmp_model("wd.drop");
      drive(5'b00010);
      check("wd.regrant1", gnt, 5'b00010);
      cmp_model("wd.regrant");
    end else begin
      for (int i = 0; i < 1005; i++) begin
        drive(5'b10010);
        if (gnt == 5'b00010) cnt_g1++;
        if (tout) cnt_to++;
      end
      check("nowd.gnt1_cycles", cnt_g1, 1005);
      check("nowd.timeout_pulses", cnt_to, 0);
      cmp_model("nowd");
    end

    // ---------------- random requests vs model ----------------
    do_reset(5'b00000);
    prev = 5'b0;
    for (int c = 0; c < 1500; c++) begin
      r = prev;
      for (int b = 0; b < 5; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      drive(r);
      cmp_model($sformatf("rnd%0d", c));
      prev = r;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
